regfile_wb_arbiter: RTL

//   Owns the register file's single write port (A3/WD3/WE3).

---
 rtl/regfile_wb_arbiter.sv | 137 +++++++++++++
 1 files changed

// File: rtl/regfile_wb_arbiter.sv
// Write-port arbiter for the register file: two writeback requesters plus a clear sweep.
// Optional macro ZERO_REG_GUARD_EN drops accepted writes to register 0 ($zero).
module regfile_wb_arbiter #(
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned NUM_REGS = 32,
    parameter int unsigned MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_data,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_data,
    output logic              req1_ready,
    input  logic              clr_start,
    output logic              clr_busy,
    output logic              clr_done,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_addr,
    output logic [DATA_W-1:0] rf_wdata
);
    localparam int unsigned WAIT_W = $clog2(MAX_WAIT + 1);

    typedef enum logic {StArb, StClear} state_e;

    state_e            state_q, state_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
    logic              starve;
    logic              acc;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_data;
    logic              rf_we_d, clr_busy_d, clr_done_d;
    logic [ADDR_W-1:0] rf_addr_d;
    logic [DATA_W-1:0] rf_wdata_d;

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        clr_cnt_d  = clr_cnt_q;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        starve     = (wait_cnt_q == WAIT_W'(MAX_WAIT));
        acc        = 1'b0;
        sel_addr   = req0_addr;
        sel_data   = req0_data;
        rf_we_d    = 1'b0;
        rf_addr_d  = rf_addr;
        rf_wdata_d = rf_wdata;
        clr_busy_d = clr_busy;
        clr_done_d = 1'b0;
        unique case (state_q)
            StArb: begin
                clr_busy_d = 1'b0;
                if (clr_start) begin
                    // First sweep write (address 0) is issued on the same edge.
                    state_d    = StClear;
                    rf_we_d    = 1'b1;
                    rf_addr_d  = '0;
                    rf_wdata_d = '0;
                    clr_busy_d = 1'b1;
                    clr_done_d = (NUM_REGS == 1);
                    clr_cnt_d  = ADDR_W'(1);
                end else begin
                    req1_ready = req1_valid & (!req0_valid | starve);
                    req0_ready = !starve | !req1_valid;
                    if (req1_valid && req1_ready) begin
                        acc      = 1'b1;
                        sel_addr = req1_addr;
                        sel_data = req1_data;
                    end else if (req0_valid && req0_ready) begin
                        acc = 1'b1;
                    end
                end
                if (req1_valid && !req1_ready) begin
                    wait_cnt_d = starve ? wait_cnt_q : wait_cnt_q + WAIT_W'(1);
                end else begin
                    wait_cnt_d = '0;
                end
                if (acc) begin
`ifdef ZERO_REG_GUARD_EN
                    if (sel_addr != '0) begin
                        rf_we_d    = 1'b1;
                        rf_addr_d  = sel_addr;
                        rf_wdata_d = sel_data;
                    end
`else
                    rf_we_d    = 1'b1;
                    rf_addr_d  = sel_addr;
                    rf_wdata_d = sel_data;
`endif
                end
            end
            StClear: begin
                rf_we_d    = 1'b1;
                rf_addr_d  = clr_cnt_q;
                rf_wdata_d = '0;
                clr_busy_d = 1'b1;
                if (clr_cnt_q == ADDR_W'(NUM_REGS - 1)) begin
                    clr_done_d = 1'b1;
                    clr_cnt_d  = '0;
                    state_d    = StArb;
                end else begin
                    clr_cnt_d = clr_cnt_q + ADDR_W'(1);
                end
            end
            default: state_d = StArb;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StArb;
            wait_cnt_q <= '0;
            clr_cnt_q  <= '0;
            rf_we      <= 1'b0;
            rf_addr    <= '0;
            rf_wdata   <= '0;
            clr_busy   <= 1'b0;
            clr_done   <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            clr_cnt_q  <= clr_cnt_d;
            rf_we      <= rf_we_d;
            rf_addr    <= rf_addr_d;
            rf_wdata   <= rf_wdata_d;
            clr_busy   <= clr_busy_d;
            clr_done   <= clr_done_d;
        end
    end

endmodule
